// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit address I2C target with byte write/read and ACK handling.
// scl/sda are synchronized into clk; all bus events come from edges of the
// synchronized lines.
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority
// filter behind the synchronizers. It rejects 1-clk pulses and adds 2 clk of latency.
//
// state      | meaning
// IDLE       | bus ignored until START
// ADDRESSING | shifting 7 address bits + R/W
// ACK_ADDR   | acknowledging our address
// WRITING    | shifting a byte from the master
// ACK_DATA   | acknowledging a written byte
// READING    | driving tx byte MSB first
// WAIT_ACK   | sampling master ACK/NACK after a read byte
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDRESSING = 4'd1,
    ACK_ADDR   = 4'd2,
    WRITING    = 4'd3,
    ACK_DATA   = 4'd4,
    READING    = 4'd5,
    WAIT_ACK   = 4'd6
  } state_e;

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic       scl_f, sda_f;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  // Synchronizer shift and edge-history next values
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_f;
    sda_prev_d = sda_f;
  end

  // Input synchronizers and previous-level registers, reset to idle-high bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  // Three-sample history of each synchronized line
  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
  end

  // Filter history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                 (scl_hist_q[1] & scl_hist_q[2]);
  assign sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                 (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  // Protocol FSM next state. START/STOP take priority over everything.
  // Each ACK state uses sda_oe_q as its phase bit: the first SCL fall asserts
  // the ACK, and the second fall ends the ACK period.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (start_det) begin
      state_d   = ADDRESSING;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end
        ADDRESSING: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (shift_q[6:0] == SLAVE_ADDR) begin
                state_d = ACK_ADDR;
                rw_d    = sda_f;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              bit_cnt_d = 4'd0;
              if (rw_q) begin
                state_d  = READING;
                shift_d  = tx_data;
                sda_oe_d = ~tx_data[7];
              end else begin
                state_d  = WRITING;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        WRITING: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = {shift_q[6:0], sda_f};
              rx_valid_d = 1'b1;
              bit_cnt_d  = 4'd0;
              state_d    = ACK_DATA;
            end
          end
        end
        ACK_DATA: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WRITING;
            end
          end
        end
        READING: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = WAIT_ACK;
            end else if (bit_cnt_q == 4'd0) begin
              // First fall after a reload from WAIT_ACK: present the MSB
              sda_oe_d = ~shift_q[7];
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        WAIT_ACK: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            bit_cnt_d = 4'd0;
            if (!sda_f) begin
              state_d = READING;
              shift_d = tx_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // FSM and registered outputs; reset releases SDA asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Testbench for i2c_slave: bit-level bus master, table-driven write vectors,
// hand-written corner sequences, and randomized transactions against a
// queue-based transaction model.
module tb_i2c_slave;
  localparam int Q = 8;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int STOP_LAT = 5;
`else
  localparam int STOP_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] state;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rx_pulses = 0;
  int rx_wide   = 0;
  logic rxv_prev = 1'b0;
  logic oe_seen  = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (rx_valid && rxv_prev) rx_wide++;
    rxv_prev = rx_valid;
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic d, input logic glitch, output logic seen);
    sda_m = d;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    seen = sda_line;
    wclk(Q);
    scl_m = 1'b0;
    if (glitch) begin
      wclk(Q / 2);
      scl_m = 1'b1;
      wclk(1);
      scl_m = 1'b0;
      wclk(Q / 2 - 1);
    end else begin
      wclk(Q);
    end
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b1;
    wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], glitch && (i == 4), s);
    clock_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  // Master reads a byte; tx_data is scrambled mid-byte (must not matter) and
  // set to next_tx before the ACK bit so a following byte loads it.
  task automatic recv_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      b[i] = s;
      if (i == 4) tx_data = 8'($urandom_range(0, 255));
    end
    tx_data = next_tx;
    clock_bit(~mack, 1'b0, s);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_rx;
    int         exp_pulses;
  } wvec_t;

  wvec_t      wtab[8];
  logic       ack, s;
  logic [7:0] b0, b1;
  int         p0;
  logic [6:0] r_addr;
  logic       r_rw, r_exp_ack;
  int         r_n;
  logic [7:0] q[$];
  logic [7:0] model_rx;
  int         model_pulses;

  initial begin
    wtab[0] = '{7'h42, 8'hA5, 1'b1, 8'hA5, 1};
    wtab[1] = '{7'h17, 8'h11, 1'b0, 8'hA5, 0};
    wtab[2] = '{7'h00, 8'h22, 1'b0, 8'hA5, 0};
    wtab[3] = '{7'h43, 8'h33, 1'b0, 8'hA5, 0};
    wtab[4] = '{7'h21, 8'h44, 1'b0, 8'hA5, 0};
    wtab[5] = '{7'h42, 8'h00, 1'b1, 8'h00, 1};
    wtab[6] = '{7'h42, 8'hFF, 1'b1, 8'hFF, 1};
    wtab[7] = '{7'h02, 8'h55, 1'b0, 8'hFF, 0};

    // Reset state
    wclk(3);
    chk("reset state", 32'(state), 0);
    chk("reset sda_oe", 32'(sda_oe), 0);
    chk("reset rx_data", 32'(rx_data), 0);
    chk("reset rx_valid", 32'(rx_valid), 0);
    rst = 1'b1;
    wclk(4);

    // Table-driven write transactions
    for (int k = 0; k < 8; k++) begin
      p0 = rx_pulses;
      oe_seen = 1'b0;
      do_start();
      send_byte({wtab[k].addr, 1'b0}, 1'b0, ack);
      chk($sformatf("tab%0d addr ack", k), 32'(ack), 32'(wtab[k].exp_ack));
      send_byte(wtab[k].data, 1'b0, ack);
      chk($sformatf("tab%0d data ack", k), 32'(ack), 32'(wtab[k].exp_ack));
      if (!wtab[k].exp_ack) chk($sformatf("tab%0d no sda_oe", k), 32'(oe_seen), 0);
      do_stop();
      chk($sformatf("tab%0d rx_data", k), 32'(rx_data), 32'(wtab[k].exp_rx));
      chk($sformatf("tab%0d pulses", k), 32'(rx_pulses - p0), 32'(wtab[k].exp_pulses));
      chk($sformatf("tab%0d state", k), 32'(state), 0);
    end
    model_rx = 8'hFF;

    // Read F6 with master NACK
    tx_data = 8'hF6;
    do_start();
    send_byte({7'h42, 1'b1}, 1'b0, ack);
    chk("rd addr ack", 32'(ack), 1);
    recv_byte(1'b0, 8'hF6, b0);
    chk("rd F6 bits", 32'(b0), 32'h0F6);
    chk("rd nack state", 32'(state), 0);
    chk("rd nack sda_oe", 32'(sda_oe), 0);
    do_stop();

    // Write 3C, repeated START, read 81 twice (ACK then NACK)
    p0 = rx_pulses;
    do_start();
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    chk("rs addr w ack", 32'(ack), 1);
    send_byte(8'h3C, 1'b0, ack);
    chk("rs data ack", 32'(ack), 1);
    tx_data = 8'h81;
    do_start();
    send_byte({7'h42, 1'b1}, 1'b0, ack);
    chk("rs addr r ack", 32'(ack), 1);
    recv_byte(1'b1, 8'h81, b0);
    recv_byte(1'b0, 8'h81, b1);
    chk("rs read0", 32'(b0), 32'h81);
    chk("rs read1", 32'(b1), 32'h81);
    chk("rs rx_data", 32'(rx_data), 32'h3C);
    chk("rs pulses", 32'(rx_pulses - p0), 1);
    do_stop();
    model_rx = 8'h3C;

    // STOP mid-byte: prompt IDLE, no rx_valid for partial byte
    p0 = rx_pulses;
    do_start();
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0, s);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b1;
    wclk(STOP_LAT);
    chk("stop latency state", 32'(state), 0);
    chk("stop sda_oe", 32'(sda_oe), 0);
    chk("stop partial pulses", 32'(rx_pulses - p0), 0);
    wclk(Q);

    // Repeated START mid-byte, then full byte
    p0 = rx_pulses;
    do_start();
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'b0, 1'b0, s);
    do_start();
    chk("rs mid state", 32'(state), 1);
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    send_byte(8'h99, 1'b0, ack);
    chk("rs mid data ack", 32'(ack), 1);
    do_stop();
    chk("rs mid rx_data", 32'(rx_data), 32'h99);
    chk("rs mid pulses", 32'(rx_pulses - p0), 1);
    model_rx = 8'h99;

    // Reset during a read after bit 3
    tx_data = 8'h00;
    do_start();
    send_byte({7'h42, 1'b1}, 1'b0, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0, s);
    chk("pre-reset sda_oe", 32'(sda_oe), 1);
    rst = 1'b0;
    #1;
    chk("async reset sda_oe", 32'(sda_oe), 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wclk(4);
    chk("reset mid state", 32'(state), 0);
    chk("reset mid rx_data", 32'(rx_data), 0);
    rst = 1'b1;
    wclk(4);
    scl_m = 1'b0;
    wclk(Q);
    oe_seen = 1'b0;
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    chk("no start ignored ack", 32'(ack), 0);
    chk("no start sda_oe", 32'(oe_seen), 0);
    chk("no start state", 32'(state), 0);
    p0 = rx_pulses;
    do_start();
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    chk("post reset addr ack", 32'(ack), 1);
    send_byte(8'h5A, 1'b0, ack);
    chk("post reset data ack", 32'(ack), 1);
    do_stop();
    chk("post reset rx_data", 32'(rx_data), 32'h5A);
    chk("post reset pulses", 32'(rx_pulses - p0), 1);
    model_rx = 8'h5A;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clk SCL glitch mid-byte must not shift an extra bit
    p0 = rx_pulses;
    do_start();
    send_byte({7'h42, 1'b0}, 1'b0, ack);
    send_byte(8'hC9, 1'b1, ack);
    chk("glitch data ack", 32'(ack), 1);
    do_stop();
    chk("glitch rx_data", 32'(rx_data), 32'hC9);
    chk("glitch pulses", 32'(rx_pulses - p0), 1);
    model_rx = 8'hC9;
`endif

    // Randomized transactions against the transaction model
    model_pulses = rx_pulses;
    for (int t = 0; t < 16; t++) begin
      r_addr = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'h42;
      r_rw = 1'($urandom_range(0, 1));
      r_n = $urandom_range(1, 3);
      r_exp_ack = (r_addr == 7'h42);
      q.delete();
      for (int k = 0; k < r_n; k++) q.push_back(8'($urandom_range(0, 255)));
      if (!r_exp_ack) r_n = 1;
      oe_seen = 1'b0;
      if (!r_rw) begin
        do_start();
        send_byte({r_addr, 1'b0}, 1'b0, ack);
        chk($sformatf("rnd%0d w addr ack", t), 32'(ack), 32'(r_exp_ack));
        for (int k = 0; k < r_n; k++) begin
          send_byte(q[k], 1'b0, ack);
          chk($sformatf("rnd%0d w data ack", t), 32'(ack), 32'(r_exp_ack));
          if (r_exp_ack) begin
            model_rx = q[k];
            model_pulses++;
          end
        end
        do_stop();
      end else begin
        tx_data = q[0];
        do_start();
        send_byte({r_addr, 1'b1}, 1'b0, ack);
        chk($sformatf("rnd%0d r addr ack", t), 32'(ack), 32'(r_exp_ack));
        for (int k = 0; k < r_n; k++) begin
          recv_byte(k != r_n - 1, (k + 1 < q.size()) ? q[k + 1] : 8'h00, b0);
          chk($sformatf("rnd%0d r byte%0d", t, k), 32'(b0), r_exp_ack ? 32'(q[k]) : 32'hFF);
        end
        do_stop();
      end
      if (!r_exp_ack) chk($sformatf("rnd%0d no sda_oe", t), 32'(oe_seen), 0);
      chk($sformatf("rnd%0d rx_data", t), 32'(rx_data), 32'(model_rx));
      chk($sformatf("rnd%0d pulses", t), 32'(rx_pulses), 32'(model_pulses));
      chk($sformatf("rnd%0d state", t), 32'(state), 0);
    end

    chk("rx_valid width", 32'(rx_wide), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42: 7-bit bus address this slave answers to.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge; clk SHALL be at least 8x the SCL frequency.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port scl, input, 1: I2C clock from the master; slave never drives SCL.
REQ-005 SHALL have port sda_in, input, 1: resolved SDA line level.
REQ-006 SHALL have port sda_oe, output, 1: 1 = pull SDA low (open-drain); 0 = release.
REQ-007 SHALL have port tx_data, input, 8: byte returned on a master read; sampled at the start of each read byte.
REQ-008 SHALL have port rx_data, output, 8: last byte received on a master write.
REQ-009 SHALL have port rx_valid, output, 1: one-clk pulse when rx_data updates.
REQ-010 SHALL have port state, output, 4: current FSM state, for bench monitoring.

Function
REQ-011 SHALL pass scl and sda_in through 2-flop synchronizers; edges are detected on synchronized values.
REQ-012 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-013 SHALL sample SDA on SCL rising edges, MSB first; SHALL change sda_oe only on SCL falling edges.
REQ-014 SHALL use state encodings IDLE=0, ADDRESSING=1, ACK_ADDR=2, WRITING=3, ACK_DATA=4, READING=5, WAIT_ACK=6.
REQ-015 IDLE: START -> ADDRESSING; bit counter cleared.
REQ-016 ADDRESSING: shift 8 bits (7 address bits + R/W).
- Address match -> ACK_ADDR.
- Mismatch -> IDLE, sda_oe held 0 until the next START.
REQ-017 ACK_ADDR: drive sda_oe=1 for the 9th SCL period.
- On the falling SCL edge ending the ACK: R/W=0 -> WRITING; R/W=1 -> load tx_data, go to READING, and drive its MSB.
REQ-018 WRITING: shift 8 bits; on the 8th bit, update rx_data, pulse rx_valid for exactly one clk, go to ACK_DATA.
REQ-019 ACK_DATA: drive ACK for one SCL period, then WRITING.
REQ-020 READING: sda_oe = ~shift_reg[7]; shift on each SCL fall; after 8 bits release SDA and go to WAIT_ACK.
REQ-021 WAIT_ACK: sample master ACK on SCL rise.
- SDA=0 -> reload tx_data and go to READING.
- SDA=1 (NACK) -> IDLE, SDA released.
REQ-022 STOP in any state SHALL go to IDLE and set sda_oe=0 within 3 clk of the synchronized edge.
REQ-023 Repeated START in any non-IDLE state SHALL go to ADDRESSING with the bit counter cleared; rx_valid SHALL NOT pulse for a partial byte.
REQ-024 A General-call address (7'h00) SHALL NOT match unless SLAVE_ADDR=0.

Reset
REQ-025 While rst=0: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, shift register and bit counter=0, synchronizers=1 (bus idle).
REQ-026 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously).
REQ-027 After reset release, the slave SHALL ignore the bus until a new START.

Configuration
REQ-028 With I2C_SLAVE_GLITCH_FILTER_EN defined, synchronized scl/sda SHALL pass a 3-sample majority filter: pulses of 1 clk are rejected and latency grows by 2 clk.
REQ-029 Without the macro, there SHALL be no filter and only the 2-flop synchronizer latency.

Verification
REQ-030 START, addr 7'h42 + W, byte 8'hA5, STOP -> ACK on 9th bit of both bytes; rx_data=8'hA5; one rx_valid pulse; state returns to 0.
REQ-031 START, addr 7'h42 + R, tx_data=8'hF6, master NACK -> SDA bits 1,1,1,1,0,1,1,0; then state=IDLE, sda_oe=0.
REQ-032 START, addr 7'h17 + W -> no ACK (SDA high on 9th bit); sda_oe stays 0 until STOP; state=IDLE.
REQ-033 Write 8'h3C then repeated START, addr 7'h42 + R, tx_data=8'h81, master ACK then NACK -> rx_data=8'h3C; two read bytes of 8'h81 sent.
REQ-034 rst pulled low mid read (after bit 3) -> sda_oe=0 same cycle; the next transfer with 8'h5A completes normally.
REQ-035 With the macro defined, a 1-clk SCL glitch mid-byte -> no extra bit shifted; the received byte stays correct.
